// File: rtl/variable_table_cluster_v2.sv
// Replicated 1-bit variable store: CLUSTER_SIZE read copies, atomic flip port, clear/LFSR init sweep.
// Latency: reads 1 cycle with write-first forwarding; a flip commits the cycle after acceptance.
// Backpressure: flip_ready_o low while busy or a flip is in flight; AXI writes dropped while busy (axi_drop_o).
module variable_table_cluster_v2 #(
    parameter int unsigned VARIABLE_ADDRESS_WIDTH = 11,
    parameter int unsigned CLUSTER_SIZE           = 40,
    parameter logic [15:0] LFSR_SEED              = 16'hACE1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            axi_en_i,
    input  logic                                            axi_wr_en_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]               axi_addr_i,
    input  logic                                            axi_data_i,
    output logic                                            axi_drop_o,
    input  logic                                            init_start_i,
    input  logic                                            init_mode_i,
    output logic                                            busy_o,
    input  logic                                            en_i,
    input  logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0]  addr_mi,
    output logic [CLUSTER_SIZE-1:0]                         data_mo,
    input  logic                                            flip_i,
    input  logic [VARIABLE_ADDRESS_WIDTH-1:0]               flip_addr_i,
    output logic                                            flip_ready_o,
    output logic                                            flip_done_o,
    output logic                                            flip_val_o
);

    localparam int unsigned   AW        = VARIABLE_ADDRESS_WIDTH;
    localparam int unsigned   D         = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(D - 1);
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic {ST_SWEEP, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic          mode_q;
    logic [AW-1:0] sweep_addr_q;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_next;

    logic          flip_pend_q;
    logic [AW-1:0] flip_addr_q;
    logic          flip_val_q;
    logic          flip_acc;
    logic          cur_bit;

    logic          hold_vld_q;
    logic [AW-1:0] hold_addr_q;
    logic          hold_dat_q;
    logic          hold_load;

    logic          drop_q;
    logic          drop_set;
    logic          start_acc;
    logic          axi_wr;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_dat;
    logic [D-1:0]  copy0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_SWEEP;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SWEEP: if (sweep_addr_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:   if (init_start_i)              state_d = ST_SWEEP;
            default:  state_d = ST_SWEEP;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // flip_ready_o drops combinationally on init_start_i so a same-cycle sweep wins.
    always_comb begin
        busy_o       = (state_q == ST_SWEEP);
        start_acc    = (state_q == ST_RUN) && init_start_i;
        flip_ready_o = (state_q == ST_RUN) && !flip_pend_q && !init_start_i;
        flip_acc     = flip_i && flip_ready_o;
    end

    assign axi_wr    = axi_en_i && axi_wr_en_i;
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // Single shared write port: sweep, else flip commit > held AXI > fresh AXI.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_dat  = 1'b0;
        if (busy_o) begin
            wr_en   = 1'b1;
            wr_addr = sweep_addr_q;
            wr_dat  = mode_q & lfsr_q[0];
        end else if (flip_pend_q) begin
            wr_en   = 1'b1;
            wr_addr = flip_addr_q;
            wr_dat  = flip_val_q;
        end else if (hold_vld_q) begin
            wr_en   = 1'b1;
            wr_addr = hold_addr_q;
            wr_dat  = hold_dat_q;
        end else if (axi_wr) begin
            wr_en   = 1'b1;
            wr_addr = axi_addr_i;
            wr_dat  = axi_data_i;
        end
    end

    assign hold_load = !busy_o && flip_pend_q && axi_wr && !hold_vld_q;
    // A held write stranded by a sweep start is lost, so it is reported like any other drop.
    assign drop_set  = (axi_wr && (busy_o || hold_vld_q)) || (busy_o && hold_vld_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q       <= 1'b0;
            sweep_addr_q <= '0;
            lfsr_q       <= LFSR_SEED;
        end else if (busy_o) begin
            sweep_addr_q <= sweep_addr_q + AW'(1);
            if (mode_q) lfsr_q <= lfsr_next;
        end else if (start_acc) begin
            mode_q       <= init_mode_i;
            sweep_addr_q <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_dat_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            hold_vld_q <= hold_load;
            if (hold_load) begin
                hold_addr_q <= axi_addr_i;
                hold_dat_q  <= axi_data_i;
            end
            if (drop_set)       drop_q <= 1'b1;
            else if (start_acc) drop_q <= 1'b0;
        end
    end

    // RMW read on copy 0 must see a write landing in the same cycle.
    assign cur_bit = (wr_en && wr_addr == flip_addr_i) ? wr_dat : copy0[flip_addr_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flip_pend_q <= 1'b0;
            flip_addr_q <= '0;
            flip_val_q  <= 1'b0;
        end else begin
            flip_pend_q <= flip_acc;
            if (flip_acc) begin
                flip_addr_q <= flip_addr_i;
                flip_val_q  <= ~cur_bit;
            end
        end
    end

    assign flip_done_o = flip_pend_q;
    assign flip_val_o  = flip_val_q;
    assign axi_drop_o  = drop_q;

    for (genvar c = 0; c < CLUSTER_SIZE; c++) begin : g_copy
        logic [D-1:0]  copy_q;
        logic [AW-1:0] rd_addr;
        logic          rd_q;

        assign rd_addr = addr_mi[c*AW +: AW];

        always_ff @(posedge clk_i) begin
            if (wr_en) copy_q[wr_addr] <= wr_dat;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_q <= 1'b0;
            end else if (busy_o) begin
                rd_q <= 1'b0;
            end else if (en_i) begin
                rd_q <= (wr_en && wr_addr == rd_addr) ? wr_dat : copy_q[rd_addr];
            end
        end

        assign data_mo[c] = rd_q & ~busy_o;

        if (c == 0) begin : g_rmw
            assign copy0 = copy_q;
        end
    end

endmodule

// File: tb/tb_variable_table_cluster_v2.sv
// Directed bench for variable_table_cluster_v2 with AW=4, CLUSTER_SIZE=4.
module tb_variable_table_cluster_v2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        axi_en_i, axi_wr_en_i, axi_data_i;
    logic [3:0]  axi_addr_i;
    logic        axi_drop_o;
    logic        init_start_i, init_mode_i;
    logic        busy_o;
    logic        en_i;
    logic [15:0] addr_mi;
    logic [3:0]  data_mo;
    logic        flip_i;
    logic [3:0]  flip_addr_i;
    logic        flip_ready_o, flip_done_o, flip_val_o;

    int tests = 0;
    int fails = 0;

    variable_table_cluster_v2 #(
        .VARIABLE_ADDRESS_WIDTH(4),
        .CLUSTER_SIZE(4),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .axi_en_i(axi_en_i), .axi_wr_en_i(axi_wr_en_i), .axi_addr_i(axi_addr_i),
        .axi_data_i(axi_data_i), .axi_drop_o(axi_drop_o),
        .init_start_i(init_start_i), .init_mode_i(init_mode_i), .busy_o(busy_o),
        .en_i(en_i), .addr_mi(addr_mi), .data_mo(data_mo),
        .flip_i(flip_i), .flip_addr_i(flip_addr_i), .flip_ready_o(flip_ready_o),
        .flip_done_o(flip_done_o), .flip_val_o(flip_val_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic sweep_len(output int n);
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task test_reset;
        int n;
        rst_ni = 1'b0;
        axi_en_i = 0; axi_wr_en_i = 0; axi_addr_i = 0; axi_data_i = 0;
        init_start_i = 0; init_mode_i = 0; en_i = 0; addr_mi = 0;
        flip_i = 0; flip_addr_i = 0;
        repeat (3) step();
        tests++;
        if ({busy_o, flip_ready_o, flip_done_o, flip_val_o, axi_drop_o, data_mo} !== 9'b1_0000_0000) begin
            fails++;
            $display("FAIL reset_values: got %b required %b",
                     {busy_o, flip_ready_o, flip_done_o, flip_val_o, axi_drop_o, data_mo}, 9'b1_0000_0000);
        end
        rst_ni = 1'b1;
        sweep_len(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL reset_sweep_len: got %0d required 16", n);
        end
        tests++;
        if (flip_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_sweep: got %b required 1", flip_ready_o);
        end
        en_i = 1;
        for (int a = 0; a < 16; a++) begin
            addr_mi = {4{4'(a)}};
            step();
            tests++;
            if (data_mo !== 4'b0000) begin
                fails++;
                $display("FAIL reset_clear addr %0d: got %b required 0000", a, data_mo);
            end
        end
    endtask

    task test_random_fill;
        int n;
        logic [15:0] lfsr_bits;
        lfsr_bits = 16'hC4E1;  // bit k = k-th LFSR bit 0 from seed ACE1
        init_mode_i = 1; init_start_i = 1;
        step();
        init_start_i = 0; init_mode_i = 0;
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            if (n == 5) begin
                axi_en_i = 1; axi_wr_en_i = 1; axi_addr_i = 4'd0; axi_data_i = 0;
            end else begin
                axi_en_i = 0; axi_wr_en_i = 0;
            end
            step();
            n++;
        end
        axi_en_i = 0; axi_wr_en_i = 0;
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL random_sweep_len: got %0d required 16", n);
        end
        tests++;
        if (axi_drop_o !== 1'b1) begin
            fails++;
            $display("FAIL drop_in_sweep: got %b required 1", axi_drop_o);
        end
        for (int a = 0; a < 16; a++) begin
            addr_mi = {4{4'(a)}};
            step();
            tests++;
            if (data_mo !== {4{lfsr_bits[a]}}) begin
                fails++;
                $display("FAIL random_fill addr %0d: got %b required %b", a, data_mo, {4{lfsr_bits[a]}});
            end
        end
    endtask

    task test_clear_sweep;
        int n;
        init_mode_i = 0; init_start_i = 1;
        step();
        init_start_i = 0;
        tests++;
        if (axi_drop_o !== 1'b0) begin
            fails++;
            $display("FAIL drop_clear: got %b required 0", axi_drop_o);
        end
        sweep_len(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL clear_sweep_len: got %0d required 16", n);
        end
        for (int a = 0; a < 16; a += 5) begin
            addr_mi = {4{4'(a)}};
            step();
            tests++;
            if (data_mo !== 4'b0000) begin
                fails++;
                $display("FAIL clear_fill addr %0d: got %b required 0000", a, data_mo);
            end
        end
    endtask

    task test_axi_write;
        axi_en_i = 1; axi_wr_en_i = 1; axi_addr_i = 4'd5; axi_data_i = 1;
        step();
        axi_en_i = 0; axi_wr_en_i = 0;
        addr_mi = {4{4'd5}};
        step();
        tests++;
        if (data_mo !== 4'b1111) begin
            fails++;
            $display("FAIL axi_write addr5: got %b required 1111", data_mo);
        end
        addr_mi = {4{4'd6}};
        step();
        tests++;
        if (data_mo !== 4'b0000) begin
            fails++;
            $display("FAIL axi_neighbor addr6: got %b required 0000", data_mo);
        end
    endtask

    task test_flip;
        flip_i = 1; flip_addr_i = 4'd3;
        #1;
        tests++;
        if (flip_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flip_ready_N: got %b required 1", flip_ready_o);
        end
        step();
        flip_i = 0;
        tests++;
        if ({flip_done_o, flip_val_o, flip_ready_o} !== 3'b110) begin
            fails++;
            $display("FAIL flip_commit1 done/val/ready: got %b required 110",
                     {flip_done_o, flip_val_o, flip_ready_o});
        end
        step();
        tests++;
        if ({flip_done_o, flip_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL flip_N2 done/ready: got %b required 01", {flip_done_o, flip_ready_o});
        end
        flip_i = 1;
        step();
        flip_i = 0;
        tests++;
        if ({flip_done_o, flip_val_o} !== 2'b10) begin
            fails++;
            $display("FAIL flip_commit2 done/val: got %b required 10", {flip_done_o, flip_val_o});
        end
        step();
    endtask

    task test_forwarding;
        flip_i = 1; flip_addr_i = 4'd3;
        step();
        flip_i = 0;
        addr_mi = {4'd7, 4'd3, 4'd7, 4'd7};
        axi_en_i = 1; axi_wr_en_i = 1; axi_addr_i = 4'd7; axi_data_i = 1;
        step();
        tests++;
        if (data_mo !== 4'b0100) begin
            fails++;
            $display("FAIL fwd_flip_commit: got %b required 0100", data_mo);
        end
        addr_mi = {4{4'd7}};
        axi_addr_i = 4'd8;
        step();
        axi_en_i = 0; axi_wr_en_i = 0;
        tests++;
        if (data_mo !== 4'b1111) begin
            fails++;
            $display("FAIL fwd_held_axi addr7: got %b required 1111", data_mo);
        end
        tests++;
        if (axi_drop_o !== 1'b1) begin
            fails++;
            $display("FAIL drop_during_stall: got %b required 1", axi_drop_o);
        end
        step();
        tests++;
        if (data_mo !== 4'b1111) begin
            fails++;
            $display("FAIL stored_axi addr7: got %b required 1111", data_mo);
        end
        addr_mi = {4{4'd8}};
        step();
        tests++;
        if (data_mo !== 4'b0000) begin
            fails++;
            $display("FAIL dropped_axi addr8: got %b required 0000", data_mo);
        end
        addr_mi = {4{4'd3}};
        step();
        tests++;
        if (data_mo !== 4'b1111) begin
            fails++;
            $display("FAIL stored_flip addr3: got %b required 1111", data_mo);
        end
    endtask

    task test_enable_hold;
        addr_mi = {4{4'd5}};
        step();
        en_i = 0;
        addr_mi = {4{4'd6}};
        step();
        tests++;
        if (data_mo !== 4'b1111) begin
            fails++;
            $display("FAIL en_low_hold: got %b required 1111", data_mo);
        end
        en_i = 1;
    endtask

    task test_start_vs_flip;
        int n;
        addr_mi = {4{4'd5}};
        step();
        init_start_i = 1; init_mode_i = 0;
        flip_i = 1; flip_addr_i = 4'd2;
        #1;
        tests++;
        if (flip_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL start_blocks_ready: got %b required 0", flip_ready_o);
        end
        step();
        init_start_i = 0; flip_i = 0;
        tests++;
        if ({busy_o, flip_done_o, axi_drop_o, data_mo} !== 7'b100_0000) begin
            fails++;
            $display("FAIL start_wins busy/done/drop/data: got %b required 1000000",
                     {busy_o, flip_done_o, axi_drop_o, data_mo});
        end
        sweep_len(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL start_sweep_len: got %0d required 16", n);
        end
        addr_mi = {4'd2, 4'd2, 4'd3, 4'd5};
        step();
        tests++;
        if (data_mo !== 4'b0000) begin
            fails++;
            $display("FAIL start_cleared: got %b required 0000", data_mo);
        end
    endtask

    task test_reset_abort;
        int n;
        init_start_i = 1; init_mode_i = 1;
        step();
        init_start_i = 0; init_mode_i = 0;
        repeat (7) step();
        rst_ni = 0;
        #1;
        tests++;
        if ({busy_o, flip_ready_o, flip_done_o, flip_val_o, axi_drop_o, data_mo} !== 9'b1_0000_0000) begin
            fails++;
            $display("FAIL abort_sweep_values: got %b required 100000000",
                     {busy_o, flip_ready_o, flip_done_o, flip_val_o, axi_drop_o, data_mo});
        end
        step();
        rst_ni = 1;
        sweep_len(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL abort_sweep_len: got %0d required 16", n);
        end
        for (int a = 0; a < 16; a++) begin
            addr_mi = {4{4'(a)}};
            step();
            tests++;
            if (data_mo !== 4'b0000) begin
                fails++;
                $display("FAIL abort_clear addr %0d: got %b required 0000", a, data_mo);
            end
        end
        flip_i = 1; flip_addr_i = 4'd9;
        step();
        flip_i = 0;
        rst_ni = 0;
        #1;
        tests++;
        if ({busy_o, flip_ready_o, flip_done_o, flip_val_o} !== 4'b1000) begin
            fails++;
            $display("FAIL abort_flip busy/ready/done/val: got %b required 1000",
                     {busy_o, flip_ready_o, flip_done_o, flip_val_o});
        end
        step();
        rst_ni = 1;
        sweep_len(n);
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL abort_flip_sweep_len: got %0d required 16", n);
        end
        addr_mi = {4{4'd9}};
        step();
        tests++;
        if (data_mo !== 4'b0000) begin
            fails++;
            $display("FAIL abort_flip_addr9: got %b required 0000", data_mo);
        end
    endtask

    initial begin
        test_reset();
        test_random_fill();
        test_clear_sweep();
        test_axi_write();
        test_flip();
        test_forwarding();
        test_enable_hold();
        test_start_vs_flip();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
